// File: rtl/fetch_pkg.sv
// +--------------------------------------------------------------------------+
// | fetch_pkg: shared types and constants for the instruction-fetch stage.    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

package fetch_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  function automatic if_id_t make_bubble(input logic [31:0] pc);
    if_id_t b;
    b.pc    = pc;
    b.instr = NOP_INSTR;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// +--------------------------------------------------------------------------+
// | if_id_reg: IF/ID pipeline register, async reset, sync flush and enable.   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module if_id_reg
  import fetch_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_flush_n,
  input  logic   i_en,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t ifid_q;
  if_id_t ifid_d;

  // Flush outranks the enable so a stalled stage can still be squashed.
  always_comb begin
    ifid_d = ifid_q;
    if (!i_flush_n) begin
      ifid_d = make_bubble(32'h0);
    end else if (i_en) begin
      ifid_d = i_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ifid_q <= make_bubble(32'h0);
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign o_q = ifid_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// +--------------------------------------------------------------------------+
// | fetch_stage: PC ownership, req/ack instruction fetch and IF/ID register.  |
// | Optional FETCH_PERF_EN macro enables stall and bubble counters.           |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable_pc,
  input  logic        i_enable_if,
  input  logic        i_reset_if,
  input  logic        pc_sel_ex,
  input  logic [31:0] i_alu_data,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] pc_id,
  output logic [31:0] instr_id,
  output logic        valid_id,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_bubble_cnt
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tgt_q, tgt_d;
  logic [31:0]  buf_q, buf_d;
  logic         kill_q, kill_d;
  logic         req_q, req_d;
  if_id_t       ifid_d;
  if_id_t       ifid_out;
  logic         adv;

  assign adv = i_enable_pc & i_enable_if;

  // ifid_d defaults to a bubble; it only becomes valid when a word is delivered.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    buf_d   = buf_q;
    kill_d  = kill_q;
    ifid_d  = make_bubble(pc_q);
    case (state_q)
      FETCH: begin
        if (i_imem_ack) begin
          if (kill_q || pc_sel_ex) begin
            pc_d   = pc_sel_ex ? i_alu_data : tgt_q;
            kill_d = 1'b0;
          end else if (adv) begin
            ifid_d.instr = i_imem_rdata;
            ifid_d.valid = 1'b1;
            pc_d         = pc_q + 32'd4;
          end else begin
            buf_d   = i_imem_rdata;
            state_d = HOLD;
          end
        end else if (pc_sel_ex) begin
          tgt_d  = i_alu_data;
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (pc_sel_ex) begin
          pc_d    = i_alu_data;
          state_d = FETCH;
        end else if (adv) begin
          ifid_d.instr = buf_q;
          ifid_d.valid = 1'b1;
          pc_d         = pc_q + 32'd4;
          state_d      = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
    req_d = (state_d == FETCH);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      tgt_q   <= 32'h0;
      buf_q   <= 32'h0;
      kill_q  <= 1'b0;
      req_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      buf_q   <= buf_d;
      kill_q  <= kill_d;
      req_q   <= req_d;
    end
  end

  if_id_reg u_if_id_reg (
    .i_clk     (i_clk),
    .i_rst_n   (i_reset),
    .i_flush_n (i_reset_if),
    .i_en      (i_enable_if),
    .i_d       (ifid_d),
    .o_q       (ifid_out)
  );

  assign o_imem_req  = req_q;
  assign o_imem_addr = pc_q;
  assign pc_id       = ifid_out.pc;
  assign instr_id    = ifid_out.instr;
  assign valid_id    = ifid_out.valid;

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic        bubble_load;

  assign bubble_load = !i_reset_if || (i_enable_if && !ifid_d.valid);

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!adv && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (bubble_load && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stall_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign o_stall_cnt  = stall_cnt_q;
  assign o_bubble_cnt = bubble_cnt_q;
`else
  assign o_stall_cnt  = 32'h0;
  assign o_bubble_cnt = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// +--------------------------------------------------------------------------+
// | tb_fetch_stage: directed self-checking bench for fetch_stage.            |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_stage;

  logic        clk;
  logic        i_reset;
  logic        i_enable_pc;
  logic        i_enable_if;
  logic        i_reset_if;
  logic        pc_sel_ex;
  logic [31:0] i_alu_data;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic [31:0] pc_id;
  logic [31:0] instr_id;
  logic        valid_id;
  logic [31:0] o_stall_cnt;
  logic [31:0] o_bubble_cnt;

  int total;
  int bad;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_enable_pc  (i_enable_pc),
    .i_enable_if  (i_enable_if),
    .i_reset_if   (i_reset_if),
    .pc_sel_ex    (pc_sel_ex),
    .i_alu_data   (i_alu_data),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_ack   (i_imem_ack),
    .i_imem_rdata (i_imem_rdata),
    .pc_id        (pc_id),
    .instr_id     (instr_id),
    .valid_id     (valid_id),
    .o_stall_cnt  (o_stall_cnt),
    .o_bubble_cnt (o_bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory word at address A is 0xC0DE_<A[15:0]>.
  always_comb i_imem_rdata = {16'hC0DE, o_imem_addr[15:0]};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b0; i_enable_pc = 1'b1; i_enable_if = 1'b1; i_reset_if = 1'b1;
    pc_sel_ex = 1'b0; i_alu_data = 32'h0; i_imem_ack = 1'b0;
    tick(); tick();
    chk("rst_pc_id", pc_id, 32'h0);
    chk("rst_instr", instr_id, 32'h0000_0013);
    chk("rst_valid", {31'h0, valid_id}, 32'h0);
    chk("rst_addr", o_imem_addr, 32'h0);
    chk("rst_stall", o_stall_cnt, 32'h0);
    chk("rst_bubble", o_bubble_cnt, 32'h0);
    i_reset = 1'b1;
    #1;
    chk("rst_req", {31'h0, o_imem_req}, 32'h1);
  endtask

  task automatic test_zero_wait();
    i_imem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("zw_pc", pc_id, 32'(k * 4));
      chk("zw_instr", instr_id, 32'hC0DE_0000 | 32'(k * 4));
      chk("zw_valid", {31'h0, valid_id}, 32'h1);
    end
    i_imem_ack = 1'b0;
  endtask

  task automatic test_latency();
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("lat_bubble_instr", instr_id, 32'h0000_0013);
      chk("lat_bubble_valid", {31'h0, valid_id}, 32'h0);
      chk("lat_addr_stable", o_imem_addr, 32'h10);
      chk("lat_req", {31'h0, o_imem_req}, 32'h1);
    end
    i_imem_ack = 1'b1;
    tick();
    i_imem_ack = 1'b0;
    chk("lat_instr", instr_id, 32'hC0DE_0010);
    chk("lat_pc", pc_id, 32'h10);
    chk("lat_valid", {31'h0, valid_id}, 32'h1);
    chk("lat_next_addr", o_imem_addr, 32'h14);
  endtask

  task automatic test_stall_hold();
    i_enable_pc = 1'b0; i_enable_if = 1'b0; i_imem_ack = 1'b1;
    tick();
    i_imem_ack = 1'b0;
    chk("hold_req0", {31'h0, o_imem_req}, 32'h0);
    chk("hold_keep_instr", instr_id, 32'hC0DE_0010);
    tick();
    chk("hold_req0_b", {31'h0, o_imem_req}, 32'h0);
    i_enable_pc = 1'b1; i_enable_if = 1'b1;
    tick();
    chk("hold_instr", instr_id, 32'hC0DE_0014);
    chk("hold_pc", pc_id, 32'h14);
    chk("hold_valid", {31'h0, valid_id}, 32'h1);
    chk("hold_req1", {31'h0, o_imem_req}, 32'h1);
    chk("hold_next_addr", o_imem_addr, 32'h18);
`ifdef FETCH_PERF_EN
    chk("perf_stall", o_stall_cnt, 32'd2);
    chk("perf_bubble", o_bubble_cnt, 32'd2);
`else
    chk("perf_stall_off", o_stall_cnt, 32'd0);
    chk("perf_bubble_off", o_bubble_cnt, 32'd0);
`endif
  endtask

  task automatic test_redirect();
    pc_sel_ex = 1'b1; i_alu_data = 32'h100;
    tick();
    pc_sel_ex = 1'b0; i_alu_data = 32'h0;
    chk("redir_inflight_addr", o_imem_addr, 32'h18);
    i_imem_ack = 1'b1;
    tick();
    chk("redir_discard_valid", {31'h0, valid_id}, 32'h0);
    chk("redir_target_addr", o_imem_addr, 32'h100);
    tick();
    i_imem_ack = 1'b0;
    chk("redir_instr", instr_id, 32'hC0DE_0100);
    chk("redir_pc", pc_id, 32'h100);
  endtask

  task automatic test_flush_redirect();
    logic [31:0] b0;
    b0 = o_bubble_cnt;
    i_reset_if = 1'b0; pc_sel_ex = 1'b1; i_alu_data = 32'h200; i_imem_ack = 1'b1;
    tick();
    i_reset_if = 1'b1; pc_sel_ex = 1'b0; i_alu_data = 32'h0; i_imem_ack = 1'b0;
    chk("flush_instr", instr_id, 32'h0000_0013);
    chk("flush_valid", {31'h0, valid_id}, 32'h0);
    chk("flush_pc_target", o_imem_addr, 32'h200);
`ifdef FETCH_PERF_EN
    chk("flush_bubble_inc", o_bubble_cnt - b0, 32'd1);
`else
    chk("flush_bubble_off", o_bubble_cnt, b0);
`endif
  endtask

  task automatic test_reset_mid_hold();
    i_imem_ack = 1'b1;
    tick();
    chk("mh_load_valid", {31'h0, valid_id}, 32'h1);
    i_enable_pc = 1'b0; i_enable_if = 1'b0;
    tick();
    i_imem_ack = 1'b0;
    chk("mh_in_hold", {31'h0, o_imem_req}, 32'h0);
    #2;
    i_reset = 1'b0;
    #1;
    chk("mh_async_valid", {31'h0, valid_id}, 32'h0);
    chk("mh_async_addr", o_imem_addr, 32'h0);
    chk("mh_async_stall", o_stall_cnt, 32'h0);
    tick();
    i_reset = 1'b1; i_enable_pc = 1'b1; i_enable_if = 1'b1;
    #1;
    chk("mh_req_after", {31'h0, o_imem_req}, 32'h1);
    i_imem_ack = 1'b1;
    tick();
    i_imem_ack = 1'b0;
    chk("mh_first_instr", instr_id, 32'hC0DE_0000);
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall_hold();
    test_redirect();
    test_flush_redirect();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the non-forwarding RISC-V pipeline: owns the PC, issues a request/acknowledge fetch to instruction memory, and drives the IF/ID pipeline register that the hazard detection unit inspects as `instr_id`. It consumes the hazard unit's PC/IF stall and flush controls, and the execute-stage redirect (`pc_sel_ex` plus the target). It tolerates multi-cycle instruction memory and absorbs stalls that arrive while a fetch is in flight.

## Interface

**Parameters**
- `RESET_PC`, default 32'h0000_0000: PC value after reset.

**Ports**
- `i_clk` in 1: single clock; all state updates on the rising edge.
- `i_reset` in 1: asynchronous, active-low reset.
- `i_enable_pc` in 1: PC advance enable, from hazard unit; 0 = stall.
- `i_enable_if` in 1: IF/ID load enable, from hazard unit; 0 = stall.
- `i_reset_if` in 1: synchronous active-low flush of IF/ID, from hazard unit.
- `pc_sel_ex` in 1: redirect request from EX.
- `i_alu_data` in 32: redirect target, valid when `pc_sel_ex`=1.
- `o_imem_req` out 1: fetch request.
- `o_imem_addr` out 32: fetch address; stable while `o_imem_req`=1.
- `i_imem_ack` in 1: data valid for the current request.
- `i_imem_rdata` in 32: instruction word.
- `pc_id` out 32: IF/ID PC.
- `instr_id` out 32: IF/ID instruction.
- `valid_id` out 1: IF/ID holds a real instruction.
- `o_stall_cnt` out 32: stall cycles (see Configuration).
- `o_bubble_cnt` out 32: bubbles inserted (see Configuration).

## Operation

- Advance condition: `adv = i_enable_pc & i_enable_if`.
- **Redirect kill flag `kill_q`:** set by `pc_sel_ex` in FETCH with no same-cycle ack.
- **FETCH state:**
  - `o_imem_req`=1 and `o_imem_addr`=`pc_q`.
  - If `pc_sel_ex` and no ack: latch `i_alu_data` into `tgt_q`, set `kill_q`, stay in FETCH.
  - On ack with `kill_q` or `pc_sel_ex`: discard data; `pc_q` <= `pc_sel_ex ? i_alu_data : tgt_q`; clear `kill_q`.
  - On ack with `adv`=1 and no kill: IF/ID <= {`pc_q`, rdata, valid=1}; `pc_q` <= `pc_q`+4 (mod 2^32).
  - On ack with `adv`=0 and no kill: `buf_q` <= rdata; go to HOLD.
  - No ack and `i_enable_if`=1: IF/ID loads a bubble {`pc_q`, NOP 32'h0000_0013, valid=0}.
- **HOLD state:**
  - `o_imem_req`=0.
  - `pc_sel_ex`: drop `buf_q`; `pc_q` <= `i_alu_data`; go to FETCH.
  - Else if `adv`: IF/ID <= {`pc_q`, `buf_q`, 1}; `pc_q`+=4; go to FETCH.
  - Else stay in HOLD.
- **IF/ID register priority:**
  1. `i_reset_if`=0: bubble, valid=0.
  2. `i_enable_if`=0: hold current contents.
  3. Otherwise load as above.
- Redirect always outranks stall; stall never loses an acknowledged word.

## Timing

- **Reset values:**
  - State = FETCH; `pc_q` = `RESET_PC`; `kill_q` = 0.
  - `pc_id` = 0, `instr_id` = NOP, `valid_id` = 0, counters = 0.
  - `o_imem_req` = 1 in the first cycle after reset release.
- Latency: an ack at edge N puts the instruction on `instr_id` after edge N.
- Throughput: zero-wait memory (ack in the same cycle as req) sustains one instruction per cycle.
- Redirect taken at edge N: the request for the target is visible after edge N, or after the pending ack edge when a fetch is in flight.
- Reset asserted mid-fetch: all state returns to reset values immediately; the later ack is ignored because the memory is reset alongside.

## Configuration

- `FETCH_PERF_EN` defined:
  - `o_stall_cnt` increments each cycle with `adv`=0.
  - `o_bubble_cnt` increments each cycle a bubble is loaded into IF/ID, from either flush or no-ack.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: both outputs are tied to 0 and no counter flops exist.

## Structure

- Shared package `fetch_pkg`:
  - `fetch_state_e` {FETCH, HOLD}.
  - `NOP_INSTR` = 32'h0000_0013.
  - `if_id_t` struct {pc, instr, valid}.
- Sub-module `if_id_reg`: async active-low reset, synchronous flush, enable, carrying `if_id_t`.

## Test plan

- Zero-wait memory, ack always 1, `adv`=1: `instr_id` follows addresses 0,4,8,C in consecutive cycles with `valid_id`=1.
- Ack at 3-cycle latency: two bubbles (NOP, valid=0) precede each instruction; `o_imem_addr` stays stable until ack.
- Ack arrives while `adv`=0 for 2 cycles: state goes to HOLD with `o_imem_req`=0; the word appears once `adv`=1 and is never re-fetched.
- `pc_sel_ex`=1 with target 0x100 one cycle before a delayed ack: the acked word is discarded and the next `o_imem_addr` is 0x100.
- `i_reset_if`=0 and `pc_sel_ex`=1 together: IF/ID becomes NOP/valid=0 and PC becomes the target. With `FETCH_PERF_EN`, `o_bubble_cnt` increments by 1.
- `i_reset` asserted mid-HOLD: `pc_q`=`RESET_PC`, `valid_id`=0, `o_imem_req`=1 after release.
